dm_port_arbiter: RTL

Two-requester arbiter and sequencer for the 64K x 32-bit data memory (active-low enable/write, combinational read, write committed at posedge). Port 0 serves the core load/store unit; port 1 serves the DMA/debug master. The block accepts requests on a valid/ready handshake and arbitrates round-robin. It drives the memory control signals and performs byte-enabled stores as a read-modify-write sequence.

---
 rtl/dm_port_arbiter_if.sv | 54 +++++
 rtl/dm_port_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle for the data-memory port arbiter: two requester ports
// (request/response) plus the memory control/data pins.
// Handshake: a request transfers in a cycle where reqN_valid and reqN_ready
// are both high; the requester holds we/be/addr/wdata stable while valid is
// high and not yet ready, and may drop valid to withdraw the request.
// rspN_valid is a one-cycle completion pulse with no back-pressure.
interface dm_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [DW/8-1:0]   req0_be;
  logic [AW-1:0]     req0_addr;
  logic [DW-1:0]     req0_wdata;
  logic              rsp0_valid;
  logic [DW-1:0]     rsp0_rdata;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [DW/8-1:0]   req1_be;
  logic [AW-1:0]     req1_addr;
  logic [DW-1:0]     req1_wdata;
  logic              rsp1_valid;
  logic [DW-1:0]     rsp1_rdata;

  logic              dm_enable_n;
  logic              dm_write_n;
  logic [AW-1:0]     dm_addr;
  logic [DW-1:0]     dm_wdata;
  logic [DW-1:0]     dm_rdata;

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_we, req0_be, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_be, req1_addr, req1_wdata,
    input  dm_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output dm_enable_n, dm_write_n, dm_addr, dm_wdata
  );

  // Requesters and memory side.
  modport master (
    output req0_valid, req0_we, req0_be, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_be, req1_addr, req1_wdata,
    output dm_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  dm_enable_n, dm_write_n, dm_addr, dm_wdata
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 64K x 32 data memory.
// Port 0 is the core load/store unit, port 1 the DMA/debug master.
// Loads and full-word stores take one memory cycle; partial stores are
// done as read-modify-write. Memory control outputs are registered and
// forced inactive while rst_n is low so no access leaks out of a reset cycle.
module dm_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  dm_port_arbiter_if.slave   bus,
  output logic [1:0]         dbg_state
);

  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    RMW_RD = 2'd2,
    RMW_WR = 2'd3
  } state_t;

  state_t          state;
  logic            last_grant;

  // Latched request fields of the access in flight.
  logic            lat_we;
  logic [BW-1:0]   lat_be;
  logic [DW-1:0]   lat_wdata;
  logic            lat_port;

  // Registered outputs.
  logic            en_n_q;
  logic            wr_n_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [1:0]      rsp_v_q;
  logic [DW-1:0]   rsp0_rdata_q;
  logic [DW-1:0]   rsp1_rdata_q;

  // Grant decision and selected request fields.
  logic            any_req;
  logic            gnt_port;
  logic            accept;
  logic            sel_we;
  logic [BW-1:0]   sel_be;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // Per-lane merge: enabled lanes take new data, others keep the old word.
  function automatic logic [DW-1:0] merge_lanes(
    input logic [DW-1:0] old_d,
    input logic [DW-1:0] new_d,
    input logic [BW-1:0] be
  );
    logic [DW-1:0] res;
    res = old_d;
    for (int i = 0; i < BW; i++) begin
      if (be[i]) res[i*8 +: 8] = new_d[i*8 +: 8];
    end
    return res;
  endfunction

  // Round-robin grant in IDLE; a tie goes to the port that did not win last.
  always_comb begin
    any_req  = bus.req0_valid | bus.req1_valid;
    gnt_port = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
    accept   = rst_n & (state == IDLE) & any_req;
    bus.req0_ready = accept & ~gnt_port;
    bus.req1_ready = accept &  gnt_port;
    sel_we    = gnt_port ? bus.req1_we    : bus.req0_we;
    sel_be    = gnt_port ? bus.req1_be    : bus.req0_be;
    sel_addr  = gnt_port ? bus.req1_addr  : bus.req0_addr;
    sel_wdata = gnt_port ? bus.req1_wdata : bus.req0_wdata;
  end

  // Sequencer: accept, drive the memory, merge partial stores, respond.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      lat_we       <= 1'b0;
      lat_be       <= '0;
      lat_wdata    <= '0;
      lat_port     <= 1'b0;
      en_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_v_q      <= '0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp_v_q <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we     <= sel_we;
            lat_be     <= sel_be;
            lat_wdata  <= sel_wdata;
            lat_port   <= gnt_port;
            last_grant <= gnt_port;
            if (!sel_we) begin
              state  <= ACC;
              en_n_q <= 1'b0;
              wr_n_q <= 1'b1;
              addr_q <= sel_addr;
            end else if (sel_be == {BW{1'b1}}) begin
              state   <= ACC;
              en_n_q  <= 1'b0;
              wr_n_q  <= 1'b0;
              addr_q  <= sel_addr;
              wdata_q <= sel_wdata;
            end else if (sel_be == '0) begin
              // Empty store: acknowledge without touching the memory.
              state <= ACC;
            end else begin
              state  <= RMW_RD;
              en_n_q <= 1'b0;
              wr_n_q <= 1'b1;
              addr_q <= sel_addr;
            end
          end
        end
        ACC: begin
          state  <= IDLE;
          en_n_q <= 1'b1;
          wr_n_q <= 1'b1;
          rsp_v_q[lat_port] <= 1'b1;
          if (lat_port) rsp1_rdata_q <= lat_we ? '0 : bus.dm_rdata;
          else          rsp0_rdata_q <= lat_we ? '0 : bus.dm_rdata;
        end
        RMW_RD: begin
          // The old word is consumed directly into the merged write data.
          state   <= RMW_WR;
          wr_n_q  <= 1'b0;
          wdata_q <= merge_lanes(bus.dm_rdata, lat_wdata, lat_be);
        end
        RMW_WR: begin
          state  <= IDLE;
          en_n_q <= 1'b1;
          wr_n_q <= 1'b1;
          rsp_v_q[lat_port] <= 1'b1;
          if (lat_port) rsp1_rdata_q <= '0;
          else          rsp0_rdata_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output drive; control strobes are held inactive during reset.
  always_comb begin
    bus.dm_enable_n = en_n_q | ~rst_n;
    bus.dm_write_n  = wr_n_q | ~rst_n;
    bus.dm_addr     = addr_q;
    bus.dm_wdata    = wdata_q;
    bus.rsp0_valid  = rsp_v_q[0] & rst_n;
    bus.rsp1_valid  = rsp_v_q[1] & rst_n;
    bus.rsp0_rdata  = rsp0_rdata_q;
    bus.rsp1_rdata  = rsp1_rdata_q;
    dbg_state       = state;
  end

endmodule
